// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue controller and its arbiter:
//   datapath widths, the logic-class opcode constants, the controller FSM
//   state type and a helper that sizes requester-id fields.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package alu_pkg;

  localparam int ALU_W = 32;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOR = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester-id width: one bit minimum so a 2-requester id is never zero-width.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. The winner is the first set
//   request bit found searching upward from i_last+1, wrapping modulo NUM_REQ.
//
//   Ports:
//     i_req   [NUM_REQ]  request vector
//     i_last  [IDW]      index of the previous winner
//     o_grant [NUM_REQ]  one-hot grant (all zero when no request)
//     o_idx   [IDW]      encoded winner index (0 when no request)
//     o_any              at least one request present
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);

  logic [IDW-1:0] w_pos;

  // Scan from the lowest priority (offset NUM_REQ, i.e. i_last itself) up to
  // the highest (offset 1) so the last match written is the true winner.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pos = IDW'((int'(i_last) + k) % NUM_REQ);
      if (i_req[w_pos]) begin
        o_grant        = '0;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//   Shares one 32-bit ALU between NUM_REQ requesters. A round-robin winner is
//   granted in IDLE, its operands/opcode are registered onto the ALU inputs,
//   the block waits ALU_LAT clocks, captures the result plus a zero flag and
//   presents it with the requester id on a valid/ready response channel.
//   Only one operation is ever in flight.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready      per-requester request handshake (ready one-hot)
//     req_a, req_b [N*32]      operands, requester i in slice [32i+31:32i]
//     req_op       [N*4]       opcode,   requester i in slice [4i+3:4i]
//     alu_a/alu_b/alu_op       registered ALU inputs
//     alu_result               ALU output, valid ALU_LAT clocks after issue
//     rsp_valid/rsp_ready      response handshake
//     rsp_result/rsp_zero/rsp_id  captured result, zero flag, issuing requester
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ALU_LAT = 1,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*ALU_W-1:0] req_a,
  input  logic [NUM_REQ*ALU_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [ALU_W-1:0]        alu_a,
  output logic [ALU_W-1:0]        alu_b,
  output logic [OP_W-1:0]         alu_op,
  input  logic [ALU_W-1:0]        alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ALU_W-1:0]        rsp_result,
  output logic                    rsp_zero,
  output logic [IDW-1:0]          rsp_id
);

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_cnt;
  logic [IDW-1:0]       r_last_grant;
  logic [ALU_W-1:0]     r_alu_a;
  logic [ALU_W-1:0]     r_alu_b;
  logic [OP_W-1:0]      r_alu_op;
  logic [ALU_W-1:0]     r_rsp_result;
  logic                 r_rsp_zero;
  logic [IDW-1:0]       r_rsp_id;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDW-1:0]       w_idx;
  logic                 w_any;

  logic [ALU_W-1:0]     w_a  [NUM_REQ];
  logic [ALU_W-1:0]     w_b  [NUM_REQ];
  logic [OP_W-1:0]      w_op [NUM_REQ];

  // Unpack the flat requester buses into per-requester arrays.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a[gi]  = req_a[ALU_W*gi +: ALU_W];
      assign w_b[gi]  = req_b[ALU_W*gi +: ALU_W];
      assign w_op[gi] = req_op[OP_W*gi +: OP_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Next state and handshake outputs. req_ready is masked while rst is high
  // so a requester never sees a grant that the reset edge would discard.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready    = rst ? '0 : w_grant;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_id     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_alu_a      <= w_a[w_idx];
            r_alu_b      <= w_b[w_idx];
            r_alu_op     <= w_op[w_idx];
            r_rsp_id     <= w_idx;
            r_last_grant <= w_idx;
            r_cnt        <= 4'(ALU_LAT - 1);
          end
        end
        WAIT: begin
          // cnt counts remaining WAIT cycles; capture on the last one so
          // WAIT spans exactly ALU_LAT clocks after issue.
          if (r_cnt == 4'd0) begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= (alu_result == '0);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_id     = r_rsp_id;

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
Shares the single 32-bit ALU datapath between NUM_REQ requesters. Round-robin arbitration grants one request at a time and drives the ALU operand/opcode inputs from registers. The block waits the fixed ALU latency, captures the result, computes the zero flag locally, and returns the result with the requester id over a valid/ready response channel. It sits between the requester front-ends and the ALU instance.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..8)
ALU_LAT, 1, ALU result latency in clocks after its operand inputs become stable (legal 1..8)
IDW, 1, id width = max(1, clog2(NUM_REQ))

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; at most one bit set
req_a  in  NUM_REQ*32  operand A; requester i uses slice [32i+31:32i]
req_b  in  NUM_REQ*32  operand B; same slicing
req_op  in  NUM_REQ*4  ALU opcode; requester i uses slice [4i+3:4i]
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_op  out  4  registered opcode to ALU
alu_result  in  32  ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_result  out  32  captured ALU result
rsp_zero  out  1  1 when rsp_result == 0
rsp_id  out  IDW  index of the requester that issued this op

Behaviour:
- Fixed: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, alu_a=0, alu_b=0, alu_op=0, last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, pick winner g as the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle. Handshake occurs in that cycle (T).
  - At the edge ending T: alu_a/alu_b/alu_op <= requester g slices, rsp_id <= g, last_grant <= g, cnt <= ALU_LAT-1, go to WAIT.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- req_ready is 0 in every state other than IDLE. Requests are never dropped; a requester holds req_valid until granted.
- WAIT:
  - alu_* outputs are held stable.
  - If cnt==0, at the edge: rsp_result <= alu_result, rsp_zero <= (alu_result==32'h0), go to RESP.
  - Otherwise cnt decrements.
  - WAIT lasts exactly ALU_LAT cycles (T+1..T+ALU_LAT).
- RESP:
  - rsp_valid=1 with rsp_result, rsp_zero and rsp_id stable.
  - On rsp_ready=1 the response is consumed and the FSM goes to IDLE.
  - Otherwise it holds in RESP indefinitely (backpressure).
- Latency: rsp_valid rises at cycle T+ALU_LAT+1. Minimum issue interval with rsp_ready held high is ALU_LAT+2 cycles.
- One operation is outstanding at a time. New requests arriving during WAIT/RESP wait in IDLE arbitration.
- Opcode is passed through unmodified; the controller does not decode it.
- Fairness: a continuously asserted requester is granted within NUM_REQ grants.
- rst asserted in any state returns all registers to reset values at that edge. An in-flight op is discarded and produces no response.
- alu_* outputs retain the last issued values in IDLE; they are don't-care to the ALU.

Decomposition:
- Shared package alu_pkg: ALU_W=32, OP_W=4, opcode constants (OP_AND=4'b0100, OP_OR=4'b0101, OP_XOR=4'b0110, OP_NOR=4'b0111), FSM state enum {IDLE, WAIT, RESP}.
- One natural sub-module: rr_arbiter (NUM_REQ request vector + last_grant in, one-hot grant + encoded index out), purely combinational. It is reusable by other shared-resource controllers.

Test Plan:
1. Single op, ALU_LAT=1: req0 A=0x0000_00F0, B=0x0000_0FF0, op=OP_AND at T -> req_ready[0]=1 at T; rsp_valid at T+2 with rsp_result=0x0000_00F0, rsp_zero=0, rsp_id=0.
2. Zero flag: req1 A=0xFFFF_FFFF, B=0xFFFF_FFFF, op=OP_XOR -> rsp_result=0, rsp_zero=1, rsp_id=1.
3. Round-robin: req0 and req1 held valid continuously, rsp_ready=1 -> grant order 0,1,0,1. Each response id matches its grant. Issue interval is ALU_LAT+2 cycles.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* held stable, req_ready stays 0 for pending req1. On rsp_ready=1 the FSM returns to IDLE and req1 is granted the next cycle.
5. Latency sweep: ALU_LAT=3 with a model ALU delayed 3 cycles, op=OP_NOR, A=0, B=0 -> rsp_result=0xFFFF_FFFF at T+4, never earlier.
6. Reset mid-op: assert rst during WAIT -> next cycle rsp_valid=0 and state IDLE, no stale response appears. The first post-reset grant goes to requester 0 when both requesters are valid.
